// File: rtl/ldm_stm_mem_addr_sequencer.sv
// ldm_stm_mem_addr_sequencer
// Memory-side address sequencer for LDM/STM block transfers. Takes a 16-bit
// register list, a base address and the P/U addressing bits, then issues one
// word address per listed register, lowest register at the lowest address,
// advancing on mem_ready_in. On completion it pulses done_out and presents
// the base-register writeback value.
//
// Ports:
//   clk_in            clock, rising edge
//   reset_in          synchronous active-high reset
//   ldm_stm_start_in  start strobe, sampled only when idle
//   data_in[15:0]     register list (bit i = register i transferred)
//   base_addr_in[31:0] base register value Rn
//   pre_index_in      P bit (1 = pre-index)
//   up_in             U bit (1 = increment)
//   mem_ready_in      memory completes the current beat
//   mem_req_out       beat valid
//   mem_addr_out[31:0] word address of the current beat
//   reg_addr_out[3:0] register index of the current beat
//   last_out          current beat is the final one
//   busy_out          transfer in progress (beats or done cycle)
//   done_out          one-cycle completion pulse
//   wb_addr_out[31:0] writeback value for Rn
module ldm_stm_mem_addr_sequencer (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        ldm_stm_start_in,
  input  logic [15:0] data_in,
  input  logic [31:0] base_addr_in,
  input  logic        pre_index_in,
  input  logic        up_in,
  input  logic        mem_ready_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  reg_addr_out,
  output logic        last_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] wb_addr_out
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DONE} state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = i[3:0];
    return idx;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d, wb_q, wb_d;
  logic [3:0]  reg_q, reg_d;
  logic        req_q, req_d, last_q, last_d, busy_q, busy_d, done_q, done_d;

  logic [4:0]  cnt;
  logic [6:0]  off;
  logic [31:0] off32, lo_addr, wb_calc;
  logic [15:0] list_nxt;

  assign cnt   = popcount16(data_in);
  assign off   = {cnt, 2'b00};
  assign off32 = {25'd0, off};

  // Beats always ascend, so only the lowest address is needed; the four
  // addressing modes differ only in where that lowest word sits.
  always_comb begin
    lo_addr = base_addr_in;
    case ({pre_index_in, up_in})
      2'b01:   lo_addr = base_addr_in;
      2'b11:   lo_addr = base_addr_in + 32'd4;
      2'b00:   lo_addr = base_addr_in - off32 + 32'd4;
      default: lo_addr = base_addr_in - off32;
    endcase
  end

  assign wb_calc  = up_in ? (base_addr_in + off32) : (base_addr_in - off32);
  // Clearing the lowest set bit of the remaining list.
  assign list_nxt = list_q & (list_q - 16'd1);

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    reg_d   = reg_q;
    req_d   = req_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        req_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (ldm_stm_start_in) begin
          list_d = data_in;
          busy_d = 1'b1;
          if (cnt != 5'd0) begin
            state_d = S_ADDR;
            req_d   = 1'b1;
            addr_d  = lo_addr;
            reg_d   = lowest_idx(data_in);
            last_d  = (cnt == 5'd1);
            wb_d    = wb_calc;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            wb_d    = base_addr_in;
          end
        end
      end
      S_ADDR: begin
        if (mem_ready_in) begin
          list_d = list_nxt;
          addr_d = addr_q + 32'd4;
          if (last_q) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            reg_d  = lowest_idx(list_nxt);
            last_d = ((list_nxt & (list_nxt - 16'd1)) == 16'd0);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      list_q  <= 16'd0;
      addr_q  <= 32'd0;
      wb_q    <= 32'd0;
      reg_q   <= 4'd0;
      req_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      reg_q   <= reg_d;
      req_q   <= req_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_req_out  = req_q;
  assign mem_addr_out = addr_q;
  assign reg_addr_out = reg_q;
  assign last_out     = last_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign wb_addr_out  = wb_q;

endmodule

// File: tb/tb_ldm_stm_mem_addr_sequencer.sv
module tb_ldm_stm_mem_addr_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in, ldm_stm_start_in, pre_index_in, up_in, mem_ready_in;
  logic [15:0] data_in;
  logic [31:0] base_addr_in;
  logic        mem_req_out, last_out, busy_out, done_out;
  logic [31:0] mem_addr_out, wb_addr_out;
  logic [3:0]  reg_addr_out;

  ldm_stm_mem_addr_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in), .ldm_stm_start_in(ldm_stm_start_in),
    .data_in(data_in), .base_addr_in(base_addr_in), .pre_index_in(pre_index_in),
    .up_in(up_in), .mem_ready_in(mem_ready_in), .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out), .reg_addr_out(reg_addr_out), .last_out(last_out),
    .busy_out(busy_out), .done_out(done_out), .wb_addr_out(wb_addr_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic        l;
  } beat_t;

  beat_t       bq[$];
  logic [31:0] wq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: the transferred registers in ascending order occupy
  // consecutive words starting at the lowest word of the block.
  task automatic push_model(input logic [15:0] list, input logic [31:0] base,
                            input logic p, input logic u);
    int n, k;
    logic [31:0] lo, wb;
    beat_t b;
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    if (u) lo = base + (p ? 32'd4 : 32'd0);
    else   lo = base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    if (n == 0) wb = base;
    else        wb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        b.r = 4'(i);
        b.a = lo + 32'(4 * k);
        b.l = (k == n - 1);
        bq.push_back(b);
        k++;
      end
    end
    wq.push_back(wb);
  endtask

  // Monitor: compares every presented beat (held or completing) and every
  // completion against the scoreboard heads.
  initial begin
    forever begin
      @(negedge clk_in);
      chk("busy", {31'd0, busy_out}, {31'd0, mem_req_out | done_out});
      if (mem_req_out) begin
        if (bq.size() == 0) begin
          chk("unexpected_beat", {31'd0, mem_req_out}, 32'd0);
        end else begin
          chk("beat_reg", {28'd0, reg_addr_out}, {28'd0, bq[0].r});
          chk("beat_addr", mem_addr_out, bq[0].a);
          chk("beat_last", {31'd0, last_out}, {31'd0, bq[0].l});
          if (mem_ready_in) void'(bq.pop_front());
        end
      end
      if (done_out) begin
        chk("done_beats_left", bq.size(), 32'd0);
        chk("done_req_low", {31'd0, mem_req_out}, 32'd0);
        if (wq.size() == 0) chk("unexpected_done", {31'd0, done_out}, 32'd0);
        else chk("wb_addr", wb_addr_out, wq.pop_front());
      end
    end
  end

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return (cyc > 3);
    endcase
  endfunction

  task automatic run(input logic [15:0] list, input logic [31:0] base, input logic p,
                     input logic u, input int mode, input bit ign);
    int n, cyc, lows;
    bit got;
    logic r;
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    push_model(list, base, p, u);
    @(posedge clk_in); #1;
    ldm_stm_start_in = 1'b1; data_in = list; base_addr_in = base;
    pre_index_in = p; up_in = u; mem_ready_in = 1'b0;
    lows = 0; got = 0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk_in); #1;
      ldm_stm_start_in = ign && (cyc == 2);
      if (ldm_stm_start_in) begin
        data_in = 16'($urandom); base_addr_in = $urandom; up_in = ~u;
      end
      r = pick_ready(mode, cyc);
      mem_ready_in = r;
      @(negedge clk_in);
      if (done_out) begin got = 1; break; end
      if (!r) lows++;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      bq.delete(); wq.delete();
    end else begin
      chk("done_cycle", 32'(cyc), 32'(n + 1 + lows));
    end
    ldm_stm_start_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},  {31'd0, mem_req_out}, 32'd0);
    chk({tag, "_addr"}, mem_addr_out, 32'd0);
    chk({tag, "_reg"},  {28'd0, reg_addr_out}, 32'd0);
    chk({tag, "_last"}, {31'd0, last_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    chk({tag, "_done"}, {31'd0, done_out}, 32'd0);
    chk({tag, "_wb"},   wb_addr_out, 32'd0);
  endtask

  initial begin
    reset_in = 1'b1; ldm_stm_start_in = 1'b0; data_in = 16'd0; base_addr_in = 32'd0;
    pre_index_in = 1'b0; up_in = 1'b0; mem_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_zero("reset");
    @(posedge clk_in); #1; reset_in = 1'b0;

    run(16'h00A5, 32'h0000_1000, 1'b0, 1'b1, 0, 1'b1);
    run(16'hC001, 32'h0000_2000, 1'b1, 1'b0, 0, 1'b0);
    run(16'h0003, 32'h0000_0100, 1'b1, 1'b1, 2, 1'b0);
    run(16'hFFFF, 32'h0000_0040, 1'b0, 1'b0, 0, 1'b0);
    run(16'h0000, 32'h1234_5678, 1'b1, 1'b0, 0, 1'b0);
    run(16'h000F, 32'hFFFF_FFF8, 1'b0, 1'b1, 0, 1'b0);

    // Reset in the middle of a transfer
    push_model(16'hFFFF, 32'h0000_3000, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    ldm_stm_start_in = 1'b1; data_in = 16'hFFFF; base_addr_in = 32'h0000_3000;
    pre_index_in = 1'b0; up_in = 1'b1; mem_ready_in = 1'b1;
    @(posedge clk_in); #1; ldm_stm_start_in = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    reset_in = 1'b1; mem_ready_in = 1'b0;
    @(posedge clk_in); #1;
    bq.delete(); wq.delete();
    @(negedge clk_in);
    chk_zero("midreset");
    @(posedge clk_in); #1; reset_in = 1'b0; mem_ready_in = 1'b1;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk_zero("postreset");

    // Start coincident with reset: reset wins
    @(posedge clk_in); #1;
    reset_in = 1'b1; ldm_stm_start_in = 1'b1; data_in = 16'h00FF; base_addr_in = 32'h0000_5000;
    @(posedge clk_in); #1; reset_in = 1'b0; ldm_stm_start_in = 1'b0;
    @(negedge clk_in);
    chk_zero("rststart");
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk_zero("rststart2");

    run(16'h8421, 32'h0000_7000, 1'b1, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      case ($urandom_range(0, 7))
        0:       l = 16'h0000;
        1:       l = 16'hFFFF;
        default: l = 16'($urandom);
      endcase
      run(l, (t % 5 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom,
          1'($urandom), 1'($urandom), int'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
